lcd_framebuffer: RTL and testbench

LCD_FRAMEBUFFER -- requirements
Module: lcd_framebuffer

---
 rtl/lcd_framebuffer_if.sv | 30 +++
 rtl/lcd_framebuffer.sv | 89 ++++++++
 tb/tb_lcd_framebuffer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_framebuffer_if.sv
// Framebuffer bus: host write/clear/present controls, LCD read port and LCD handshake.
`timescale 1ns/1ps
interface lcd_framebuffer_if;
  logic       wr_en;
  logic [5:0] wr_x;
  logic [5:0] wr_y;
  logic [3:0] wr_color;
  logic       clear;
  logic [3:0] clear_color;
  logic       present;
  logic [5:0] fb_x;
  logic [5:0] fb_y;
  logic [3:0] fb_frame;
  logic       lcd_ready;
  logic       lcd_update;
  logic       busy;
  logic       wr_err;

  modport master (
    output wr_en, wr_x, wr_y, wr_color, clear, clear_color, present,
           fb_x, fb_y, lcd_ready,
    input  fb_frame, lcd_update, busy, wr_err
  );

  modport slave (
    input  wr_en, wr_x, wr_y, wr_color, clear, clear_color, present,
           fb_x, fb_y, lcd_ready,
    output fb_frame, lcd_update, busy, wr_err
  );
endinterface

// File: rtl/lcd_framebuffer.sv
// 4-bit colour framebuffer with background fill engine and LCD refresh handshake.
`timescale 1ns/1ps
module lcd_framebuffer #(
  parameter int FB_W = 60,
  parameter int FB_H = 32
) (
  input  logic               clk,
  input  logic               rst,
  lcd_framebuffer_if.slave   bus
);
  localparam int CELLS = FB_W * FB_H;
  localparam int AW    = 11;

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state_q;
  logic            pending_q;
  logic            lcd_update_q;
  logic            wr_err_q;
  logic [AW-1:0]   clr_cnt_q;
  logic [3:0]      clr_color_q;
  logic [3:0]      mem_q [CELLS];

  logic            wr_in_range, wr_ok, rd_ok;
  logic [AW-1:0]   wr_addr, rd_addr;

  assign wr_in_range = (32'(bus.wr_x) < FB_W) && (32'(bus.wr_y) < FB_H);
  assign wr_ok       = bus.wr_en && wr_in_range && (state_q != CLEAR);
  assign wr_addr     = AW'(bus.wr_y) * AW'(FB_W) + AW'(bus.wr_x);

  assign rd_ok       = (32'(bus.fb_x) < FB_W) && (32'(bus.fb_y) < FB_H);
  assign rd_addr     = AW'(bus.fb_y) * AW'(FB_W) + AW'(bus.fb_x);
  assign bus.fb_frame = rd_ok ? mem_q[rd_addr] : 4'd0;

  // Cell storage is deliberately unreset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem_q[clr_cnt_q] <= clr_color_q;
    else if (wr_ok)
      mem_q[wr_addr] <= bus.wr_color;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      lcd_update_q <= 1'b0;
      wr_err_q     <= 1'b0;
      clr_cnt_q    <= '0;
      clr_color_q  <= 4'd0;
    end else begin
      lcd_update_q <= 1'b0;
      if (bus.present)
        pending_q <= 1'b1;
      if (bus.wr_en && !wr_ok)
        wr_err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.clear) begin
            clr_color_q <= bus.clear_color;
            clr_cnt_q   <= '0;
            state_q     <= CLEAR;
          end else if (pending_q && bus.lcd_ready) begin
            lcd_update_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        CLEAR: begin
          if (clr_cnt_q == AW'(CELLS - 1))
            state_q <= IDLE;
          else
            clr_cnt_q <= clr_cnt_q + 1'b1;
        end
        ISSUE: begin
          // A present arriving in the issue cycle is a new request, keep it.
          pending_q <= bus.present;
          state_q   <= WAIT_BUSY;
        end
        WAIT_BUSY: if (!bus.lcd_ready) state_q <= WAIT_DONE;
        WAIT_DONE: if (bus.lcd_ready)  state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign bus.lcd_update = lcd_update_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.busy       = (state_q != IDLE) | pending_q;
endmodule

// File: tb/tb_lcd_framebuffer.sv
// Randomized bench for lcd_framebuffer against an array model of the cells.
`timescale 1ns/1ps
module tb_lcd_framebuffer;
  localparam int W = 60;
  localparam int H = 32;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst = 1'b0;
  lcd_framebuffer_if bus();
  lcd_framebuffer #(.FB_W(W), .FB_H(H)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int model [N];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0; #1; rst = 1'b1;
    step();
  endtask

  task automatic rd(input int x, input int y, output logic [3:0] v);
    bus.fb_x = 6'(x); bus.fb_y = 6'(y);
    @(negedge clk); v = bus.fb_frame;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int x, input int y, input int c);
    bus.wr_en = 1'b1; bus.wr_x = 6'(x); bus.wr_y = 6'(y); bus.wr_color = 4'(c);
    step();
    bus.wr_en = 1'b0;
    if (x < W && y < H) model[y*W + x] = c;
  endtask

  task automatic scan(output int bad);
    logic [3:0] v;
    bad = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        rd(x, y, v);
        if (v !== 4'(model[y*W + x])) bad++;
      end
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.wr_x = 0; bus.wr_y = 0; bus.wr_color = 0;
    bus.clear = 0; bus.clear_color = 0; bus.present = 0;
    bus.fb_x = 0; bus.fb_y = 0; bus.lcd_ready = 1;
    rst = 1'b0;
    repeat (3) step();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    tests++; if (bus.lcd_update !== 1'b0) begin fails++; $display("FAIL reset_update got %b exp 0", bus.lcd_update); end
    tests++; if (bus.wr_err !== 1'b0) begin fails++; $display("FAIL reset_wr_err got %b exp 0", bus.wr_err); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_clear();
    int n, bad;
    bus.clear = 1; bus.clear_color = 4'd8;
    step();
    bus.clear = 0;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL clear_busy_start got %b exp 1", bus.busy); end
    n = 0;
    while (bus.busy === 1'b1 && n < 5000) begin
      if (n == 500) begin bus.wr_en = 1; bus.wr_x = 3; bus.wr_y = 2; bus.wr_color = 4'd1; end
      if (n == 501) bus.wr_en = 0;
      if (n == 700) begin bus.clear = 1; bus.clear_color = 4'd3; end
      if (n == 701) bus.clear = 0;
      step(); n++;
    end
    for (int i = 0; i < N; i++) model[i] = 8;
    tests++; if (n != N) begin fails++; $display("FAIL clear_busy_cycles got %0d exp %0d", n, N); end
    tests++; if (bus.wr_err !== 1'b1) begin fails++; $display("FAIL clear_wr_err got %b exp 1", bus.wr_err); end
    scan(bad);
    tests++; if (bad != 0) begin fails++; $display("FAIL clear_fill bad_cells got %0d exp 0", bad); end
    pulse_reset();
    tests++; if (bus.wr_err !== 1'b0) begin fails++; $display("FAIL wr_err_reset got %b exp 0", bus.wr_err); end
  endtask

  task automatic test_write();
    logic [3:0] v;
    int x, y, c;
    do_write(3, 2, 5);
    rd(3, 2, v);
    tests++; if (v !== 4'd5) begin fails++; $display("FAIL write_3_2 got %0d exp 5", v); end
    rd(4, 2, v);
    tests++; if (v !== 4'(model[2*W + 4])) begin fails++; $display("FAIL write_4_2 got %0d exp %0d", v, model[2*W+4]); end
    for (int k = 0; k < 30; k++) begin
      x = $urandom_range(0, W-1); y = $urandom_range(0, H-1); c = $urandom_range(0, 15);
      do_write(x, y, c);
      rd(x, y, v);
      tests++; if (v !== 4'(c)) begin fails++; $display("FAIL write_rand (%0d,%0d) got %0d exp %0d", x, y, v, c); end
      rd((x+1) % W, y, v);
      tests++; if (v !== 4'(model[y*W + (x+1)%W])) begin fails++; $display("FAIL write_neigh (%0d,%0d) got %0d exp %0d", (x+1)%W, y, v, model[y*W+(x+1)%W]); end
    end
    tests++; if (bus.wr_err !== 1'b0) begin fails++; $display("FAIL write_no_err got %b exp 0", bus.wr_err); end
  endtask

  task automatic test_oob();
    logic [3:0] v;
    int bad;
    do_write(60, 0, 7);
    tests++; if (bus.wr_err !== 1'b1) begin fails++; $display("FAIL oob_x_err got %b exp 1", bus.wr_err); end
    do_write(0, 32, 7);
    for (int k = 0; k < 8; k++)
      if (k[0]) do_write($urandom_range(W, 63), $urandom_range(0, 63), $urandom_range(0, 15));
      else      do_write($urandom_range(0, 63), $urandom_range(H, 63), $urandom_range(0, 15));
    rd(60, 0, v);
    tests++; if (v !== 4'd0) begin fails++; $display("FAIL oob_rd_x60 got %0d exp 0", v); end
    rd(0, 32, v);
    tests++; if (v !== 4'd0) begin fails++; $display("FAIL oob_rd_y32 got %0d exp 0", v); end
    rd(63, 63, v);
    tests++; if (v !== 4'd0) begin fails++; $display("FAIL oob_rd_63 got %0d exp 0", v); end
    scan(bad);
    tests++; if (bad != 0) begin fails++; $display("FAIL oob_no_change bad_cells got %0d exp 0", bad); end
    tests++; if (bus.wr_err !== 1'b1) begin fails++; $display("FAIL oob_sticky got %b exp 1", bus.wr_err); end
    pulse_reset();
  endtask

  task automatic test_present_notready();
    int ups, n, bb;
    bus.lcd_ready = 0;
    step();
    bus.present = 1; step(); bus.present = 0;
    ups = 0;
    repeat (20) begin if (bus.lcd_update === 1'b1) ups++; step(); end
    tests++; if (ups != 0) begin fails++; $display("FAIL notready_update got %0d exp 0", ups); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL notready_busy got %b exp 1", bus.busy); end
    bus.lcd_ready = 1;
    n = 0;
    while (bus.lcd_update !== 1'b1 && n < 10) begin step(); n++; end
    tests++; if (n != 1) begin fails++; $display("FAIL ready_update_latency got %0d exp 1", n); end
    step();
    tests++; if (bus.lcd_update !== 1'b0) begin fails++; $display("FAIL update_single got %b exp 0", bus.lcd_update); end
    bb = 0; ups = 0;
    repeat (4) begin step(); if (bus.busy !== 1'b1) bb++; if (bus.lcd_update === 1'b1) ups++; end
    bus.lcd_ready = 0;
    repeat (5) begin step(); if (bus.busy !== 1'b1) bb++; if (bus.lcd_update === 1'b1) ups++; end
    tests++; if (bb != 0) begin fails++; $display("FAIL busy_hold idle_cycles got %0d exp 0", bb); end
    tests++; if (ups != 0) begin fails++; $display("FAIL extra_update got %0d exp 0", ups); end
    bus.lcd_ready = 1;
    step();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL busy_release got %b exp 0", bus.busy); end
  endtask

  task automatic test_clear_present();
    int c, n, ups, bad;
    c = $urandom_range(0, 15);
    bus.lcd_ready = 1;
    bus.clear = 1; bus.clear_color = 4'(c); bus.present = 1;
    bus.wr_en = 1; bus.wr_x = 5; bus.wr_y = 5; bus.wr_color = 4'(c ^ 1);
    step();
    bus.clear = 0; bus.present = 0; bus.wr_en = 0;
    for (int i = 0; i < N; i++) model[i] = c;
    n = 0;
    while (bus.lcd_update !== 1'b1 && n < 3000) begin step(); n++; end
    tests++; if (n != N + 1) begin fails++; $display("FAIL clr_pres_latency got %0d exp %0d", n, N + 1); end
    step();
    bus.lcd_ready = 0;
    step();
    bus.present = 1; step(); bus.present = 0;
    bus.lcd_ready = 1;
    ups = 0;
    repeat (20) begin step(); if (bus.lcd_update === 1'b1) ups++; end
    tests++; if (ups != 1) begin fails++; $display("FAIL second_update count got %0d exp 1", ups); end
    bus.lcd_ready = 0; step(); step();
    bus.lcd_ready = 1; step();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL clr_pres_idle got %b exp 0", bus.busy); end
    scan(bad);
    tests++; if (bad != 0) begin fails++; $display("FAIL clr_pres_fill bad_cells got %0d exp 0", bad); end
  endtask

  task automatic test_reset_midfill();
    int c, bad;
    c = (model[0] + $urandom_range(1, 15)) % 16;
    bus.clear = 1; bus.clear_color = 4'(c);
    step();
    bus.clear = 0;
    repeat (1000) step();
    rst = 1'b0; #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midfill_busy got %b exp 0", bus.busy); end
    tests++; if (bus.lcd_update !== 1'b0) begin fails++; $display("FAIL midfill_update got %b exp 0", bus.lcd_update); end
    for (int i = 0; i < 1000; i++) model[i] = c;
    rst = 1'b1;
    step();
    scan(bad);
    tests++; if (bad != 0) begin fails++; $display("FAIL midfill_cells bad_cells got %0d exp 0", bad); end
  endtask

  task automatic test_back_to_back();
    int xs[16], ys[16], c;
    logic [3:0] v;
    for (int k = 0; k < 16; k++) begin
      xs[k] = $urandom_range(0, W-1); ys[k] = $urandom_range(0, H-1); c = $urandom_range(0, 15);
      bus.wr_en = 1; bus.wr_x = 6'(xs[k]); bus.wr_y = 6'(ys[k]); bus.wr_color = 4'(c);
      model[ys[k]*W + xs[k]] = c;
      step();
    end
    bus.wr_en = 0;
    for (int k = 0; k < 16; k++) begin
      rd(xs[k], ys[k], v);
      tests++; if (v !== 4'(model[ys[k]*W + xs[k]])) begin fails++; $display("FAIL b2b (%0d,%0d) got %0d exp %0d", xs[k], ys[k], v, model[ys[k]*W+xs[k]]); end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write();
    test_oob();
    test_present_notready();
    test_clear_present();
    test_reset_midfill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
